count8d: RTL and testbench
==========================

# count8d

Loadable 8-bit down counter with borrow output, the counting-direction counterpart of the team's up counter (`count8a`). It supports three modes: free-running wrap, periodic auto-reload and one-shot. Typical uses are programmable timers, baud or tick dividers and terminal-count generation. Several instances cascade through `Bo`/`En` in the same way the up counters cascade through their carry.

## Interface
- `WIDTH`, default 8: counter width. Only 8 is verified.
- `Clk`  input  1: single clock; all state changes on the rising edge.
- `Res`  input  1: reset, synchronous, active-high.
- `En`  input  1: count enable; the counter decrements once per enabled edge.
- `Load`  input  1: loads `cnt_in` into both the counter and the reload register.
- `Mode`  input  2: operating mode, encodings listed under Structure.
- `cnt_in`  input  WIDTH: load value.
- `cnt`  output  WIDTH: current count.
- `Zero`  output  1: combinational, `cnt == 0`.
- `Bo`  output  1: combinational borrow/terminal-count strobe, used for cascading.
- `Done`  output  1: registered, sticky one-shot completion flag.

## Operation
- Edge priority: `Res` > `Load` > `En`. With no enable and no load, all state holds.
- `Res`: `cnt`=0, `rld`=0, `Done`=0, FSM state=`ST_RUN`.
- `Load`: `cnt`<=`cnt_in`, `rld`<=`cnt_in`, `Done`<=0, FSM state<=`ST_RUN`.
  - No decrement occurs in the same cycle, even when `En`=1.
- `En` with `cnt`≠0, any mode except when stopped in `ST_DONE`: `cnt`<=`cnt`-1.
- `En` with `cnt`=0 (the terminal event):
  - `MODE_WRAP`: `cnt`<=8'hFF.
  - `MODE_RELOAD`: `cnt`<=`rld`.
  - `MODE_ONESHOT` in `ST_RUN`: `cnt` holds 0, `Done`<=1, state<=`ST_DONE`.
  - `MODE_ONESHOT` in `ST_DONE`: no change.
- `Bo` = `En` & `Zero` & ~`Res` & ~`Load` & ~(`Mode`==`MODE_ONESHOT` & state==`ST_DONE`).
  - `Bo` marks exactly the enabled cycles in which a terminal event occurs.
- One-shot FSM:
  - `ST_RUN` -> `ST_DONE` on a terminal event in `MODE_ONESHOT`.
  - `ST_DONE` -> `ST_RUN` on `Load`, on `Res`, or at the first edge where `Mode`≠`MODE_ONESHOT`; `Done` clears on that same edge.
- `Mode`=2'b11 (reserved) behaves as `MODE_WRAP`.
- Toggle rule for bit i: toggle enable = `En` & (`cnt[i-1:0]`==0).
  - This borrow chain is the inverted-bit dual of the up-counter carry chain.
- Arithmetic is modulo 2^WIDTH. There is no other overflow or underflow path.

## Timing
- `cnt`, `rld`, `Done` and the FSM state are registered. All reset to 0 / `ST_RUN`.
- Reset values of the combinational outputs while `Res`=1: `Bo`=0; `Zero` reflects `cnt` and is 1 after the reset edge.
- `Zero` and `Bo` are combinational from state and inputs, with zero latency.
- `cnt` reflects a load or decrement one edge after the request.
- Auto-reload period for a loaded value N: N+1 enabled cycles between `Bo` strobes.
  - N=0 gives `Bo` on every enabled cycle.
- Wrap mode period: 256 enabled cycles.
- One-shot latency: N enabled edges after a load of N, `cnt`=0. The next enabled edge raises `Bo` for exactly one cycle and sets `Done`.
- A `Mode` change takes effect at the next edge. No state is lost except the `ST_DONE` exit described above.
- `Res` asserted mid-count: the next edge clears everything, regardless of `Load`/`En`.
- Asserting `Load` while `Bo` would fire: load wins and `Bo`=0.

## Structure
- The shared include `count_defs.vh` holds:
  - `MODE_WRAP`=2'b00, `MODE_RELOAD`=2'b01, `MODE_ONESHOT`=2'b10, `MODE_RSVD`=2'b11.
  - `ST_RUN`=1'b0, `ST_DONE`=1'b1.
  - `CNT_W`=8.
- Counter core: per-bit `tflipflop` cells driven by the borrow chain. Each cell's `Din` is taken from a mux:
  - `cnt_in` on `Load`;
  - `rld` on a reload terminal event;
  - all-ones on a wrap terminal event.
- One new sub-module, `count8d_ctrl`, contains:
  - mode decode;
  - the one-shot FSM and the `Done` register;
  - the `Bo` gating;
  - the load/reload select for the `Din` mux.

## Test plan
- Reset: hold `Res` 2 cycles with `En`=1, `Load`=1 -> `cnt`=0, `Done`=0, `Bo`=0; `Zero`=1 after release.
- Wrap: load 8'h03, `Mode`=00, `En`=1 for 5 cycles -> `cnt` 3,2,1,0,FF,FE; `Bo` high only in the cnt=0 cycle.
- Reload: load 8'h02, `Mode`=01, `En`=1 for 9 cycles -> `cnt` 2,1,0,2,1,0,2,1,0; `Bo` every third cycle; then load 8'h00 -> `Bo` held high while enabled.
- One-shot: load 8'h04, `Mode`=10, `En`=1 for 8 cycles -> reaches 0 after 4 edges, a single `Bo` pulse, then `Done`=1 with `cnt` held at 0; `Load` 8'h01 clears `Done` and counting resumes.
- Priority/collision: `Load`=1 with `En`=1 at `cnt`=0 in reload mode -> `cnt`=`cnt_in`, `Bo`=0; `Res`+`Load` together -> all zero; `En` toggling 1,0,1 from `cnt`=5 -> 5,4,4,3.
- Cascade: two instances with `Bo` of the low counter feeding `En` of the high counter, wrap mode, load 16'h0100 -> after 1 enabled cycle, value 16'h00FF; after 256 more, 16'hFFFF.

Source files
------------

// File: rtl/count8d_pkg.sv
// Shared definitions for the count8d loadable down counter: mode and
// one-shot state encodings, the counter width, and the Din mux select.
package count8d_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Source written into the counter bits when they are loaded rather than toggled.
    typedef enum logic [1:0] {
        DIN_LOAD   = 2'b00,
        DIN_RELOAD = 2'b01,
        DIN_ONES   = 2'b10
    } din_sel_e;

    // The reserved encoding decodes as wrap so an unexpected Mode cannot stall the counter.
    function automatic logic is_wrap_mode(input mode_e m);
        return (m == MODE_WRAP) || (m == MODE_RSVD);
    endfunction

endpackage

// File: rtl/count8d_ctrl.sv
// Control slice of count8d: mode decode, one-shot FSM with the sticky Done
// flag, borrow gating, and selection of what the counter cells load.
module count8d_ctrl
    import count8d_pkg::*;
(
    input  logic       clk_i,
    input  logic       res_i,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [1:0] mode_i,
    input  logic       zero_i,
    output logic       bo_o,
    output logic       done_o,
    output logic       din_we_o,
    output logic       dec_en_o,
    output din_sel_e   din_sel_o
);

    mode_e  mode;
    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   oneshot_mode, reload_mode, wrap_mode;
    logic   stopped, live, terminal;

    assign mode = mode_e'(mode_i);

    // Mode decode and the gating shared by borrow and decrement.
    always_comb begin
        oneshot_mode = (mode == MODE_ONESHOT);
        reload_mode  = (mode == MODE_RELOAD);
        wrap_mode    = is_wrap_mode(mode);
        // A finished one-shot ignores En until it is reloaded or the mode changes.
        stopped      = oneshot_mode && (state_q == ST_DONE);
        // An enabled edge that neither reset nor load pre-empts.
        live         = en_i && !res_i && !load_i && !stopped;
        terminal     = live && zero_i;
    end

    assign bo_o     = terminal;
    assign dec_en_o = live && !zero_i;
    assign done_o   = done_q;

    // Cells take parallel data on a load, or on a terminal event that must not
    // simply hold (one-shot holds 0, so it needs no write).
    assign din_we_o = !res_i && (load_i || (terminal && (reload_mode || wrap_mode)));

    // Choose the parallel data source for the counter cells.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        din_sel_o = DIN_ONES;
        if (load_i) begin
            din_sel_o = DIN_LOAD;
        end else if (terminal && reload_mode) begin
            din_sel_o = DIN_RELOAD;
        end
    end

    // One-shot FSM next state and Done flag.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        if (load_i) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (terminal && oneshot_mode) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!oneshot_mode) begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM state and Done registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (res_i) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/count8d.sv
// count8d: loadable down counter with borrow output and wrap, auto-reload
// and one-shot modes. The count is built from per-bit toggle cells whose
// toggle enables form a borrow chain; cascades through Bo -> En.
module count8d
    import count8d_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             En,
    input  logic             Load,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt,
    output logic             Zero,
    output logic             Bo,
    output logic             Done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] toggle_en;
    logic             din_we;
    logic             dec_en;
    din_sel_e         din_sel;

    count8d_ctrl u_ctrl (
        .clk_i     (Clk),
        .res_i     (Res),
        .en_i      (En),
        .load_i    (Load),
        .mode_i    (Mode),
        .zero_i    (Zero),
        .bo_o      (Bo),
        .done_o    (Done),
        .din_we_o  (din_we),
        .dec_en_o  (dec_en),
        .din_sel_o (din_sel)
    );

    assign cnt  = cnt_q;
    assign Zero = (cnt_q == '0);

    // Parallel data mux feeding every cell's Din.
    always_comb begin
        din = '1;
        unique case (din_sel)
            DIN_LOAD:   din = cnt_in;
            DIN_RELOAD: din = rld_q;
            DIN_ONES:   din = '1;
            default:    din = '1;
        endcase
    end

    // Borrow chain and per-bit toggle cells: bit i toggles when every lower
    // bit is already 0, the inverted dual of the up counter's carry chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign toggle_en[i] = dec_en;
        end else begin : g_upper
            assign toggle_en[i] = dec_en && (cnt_q[i-1:0] == '0);
        end
        assign cnt_d[i] = din_we ? din[i] : (cnt_q[i] ^ toggle_en[i]);
    end

    assign rld_d = Load ? cnt_in : rld_q;

    // Count and reload registers; reset clears both, including the reload value.
    always_ff @(posedge Clk) begin
        if (Res) begin
            cnt_q <= '0;
            rld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
        end
    end

endmodule

// File: tb/tb_count8d.sv
// Directed bench for count8d: reset, wrap, reload, one-shot, priority
// collisions and a two-stage cascade, each step with hand-computed values.
module tb_count8d;

    logic       Clk;
    logic       Res, En, Load;
    logic [1:0] Mode;
    logic [7:0] cnt_in, cnt;
    logic       Zero, Bo, Done;

    // Cascade pair: low counter's Bo drives the high counter's En.
    logic       c_load, c_en;
    logic [7:0] lo_cnt, hi_cnt;
    logic       lo_zero, lo_bo, lo_done;
    logic       hi_zero, hi_bo, hi_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_w [0:5] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
    logic [7:0] exp_o [0:7] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    count8d #(.WIDTH(8)) dut (
        .Clk(Clk), .Res(Res), .En(En), .Load(Load), .Mode(Mode),
        .cnt_in(cnt_in), .cnt(cnt), .Zero(Zero), .Bo(Bo), .Done(Done)
    );

    count8d #(.WIDTH(8)) u_lo (
        .Clk(Clk), .Res(Res), .En(c_en), .Load(c_load), .Mode(2'b00),
        .cnt_in(8'h00), .cnt(lo_cnt), .Zero(lo_zero), .Bo(lo_bo), .Done(lo_done)
    );

    count8d #(.WIDTH(8)) u_hi (
        .Clk(Clk), .Res(Res), .En(lo_bo), .Load(c_load), .Mode(2'b00),
        .cnt_in(8'h01), .cnt(hi_cnt), .Zero(hi_zero), .Bo(hi_bo), .Done(hi_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and move 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Res = 1'b1; En = 1'b1; Load = 1'b1; Mode = 2'b00; cnt_in = 8'hAA;
        c_load = 1'b0; c_en = 1'b0;

        // Reset held two cycles with En and Load active.
        tick();
        tick();
        check("rst_cnt", 16'(cnt), 16'h0000);
        check("rst_done", 16'(Done), 16'h0000);
        check("rst_bo", 16'(Bo), 16'h0000);
        check("rst_zero", 16'(Zero), 16'h0001);
        Res = 1'b0; Load = 1'b0; En = 1'b0;
        #1;
        check("rel_zero", 16'(Zero), 16'h0001);
        check("rel_bo", 16'(Bo), 16'h0000);

        // Wrap mode from 3.
        Mode = 2'b00; Load = 1'b1; cnt_in = 8'h03;
        tick();
        Load = 1'b0; En = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("wrap_cnt", 16'(cnt), 16'(exp_w[k]));
            check("wrap_bo", 16'(Bo), 16'(exp_w[k] == 8'h00));
            tick();
        end
        check("wrap_end", 16'(cnt), 16'(exp_w[5]));

        // Auto-reload with N=2: period of three enabled cycles.
        En = 1'b0; Mode = 2'b01; Load = 1'b1; cnt_in = 8'h02;
        tick();
        Load = 1'b0; En = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] e;
            e = (k % 3 == 0) ? 8'h02 : ((k % 3 == 1) ? 8'h01 : 8'h00);
            check("rld_cnt", 16'(cnt), 16'(e));
            check("rld_bo", 16'(Bo), 16'(e == 8'h00));
            tick();
        end
        check("rld_after", 16'(cnt), 16'h0002);

        // Reload value 0: Bo on every enabled cycle.
        Load = 1'b1; cnt_in = 8'h00;
        tick();
        Load = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rld0_cnt", 16'(cnt), 16'h0000);
            check("rld0_bo", 16'(Bo), 16'h0001);
            tick();
        end

        // Load collides with a terminal event: load wins, no borrow.
        Load = 1'b1; cnt_in = 8'h37;
        #1;
        check("coll_bo", 16'(Bo), 16'h0000);
        tick();
        Load = 1'b0; En = 1'b0;
        check("coll_cnt", 16'(cnt), 16'h0037);

        // One-shot from 4.
        Mode = 2'b10; Load = 1'b1; cnt_in = 8'h04;
        tick();
        Load = 1'b0; En = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("os_cnt", 16'(cnt), 16'(exp_o[k]));
            check("os_bo", 16'(Bo), 16'(k == 4));
            check("os_done", 16'(Done), 16'(k > 4));
            tick();
        end
        check("os_hold_cnt", 16'(cnt), 16'h0000);
        check("os_hold_done", 16'(Done), 16'h0001);

        // Reload of a finished one-shot clears Done and resumes counting.
        Load = 1'b1; cnt_in = 8'h01;
        #1;
        check("os_ld_bo", 16'(Bo), 16'h0000);
        tick();
        Load = 1'b0;
        #1;
        check("os_ld_done", 16'(Done), 16'h0000);
        check("os_ld_cnt", 16'(cnt), 16'h0001);
        tick();
        check("os2_cnt", 16'(cnt), 16'h0000);
        check("os2_bo", 16'(Bo), 16'h0001);
        tick();
        check("os2_done", 16'(Done), 16'h0001);

        // Leaving one-shot mode exits ST_DONE and clears Done.
        En = 1'b0; Mode = 2'b00;
        tick();
        check("exit_done", 16'(Done), 16'h0000);
        En = 1'b1;
        #1;
        check("exit_bo", 16'(Bo), 16'h0001);
        tick();
        check("exit_wrap", 16'(cnt), 16'h00FF);

        // En pattern 1,0,1 from 5.
        En = 1'b0; Load = 1'b1; cnt_in = 8'h05;
        tick();
        Load = 1'b0;
        check("en_5", 16'(cnt), 16'h0005);
        En = 1'b1;
        tick();
        check("en_4", 16'(cnt), 16'h0004);
        En = 1'b0;
        tick();
        check("en_hold", 16'(cnt), 16'h0004);
        En = 1'b1;
        tick();
        check("en_3", 16'(cnt), 16'h0003);

        // Reset with Load and En mid-count clears everything, reload value included.
        Res = 1'b1; Load = 1'b1; cnt_in = 8'h99;
        #1;
        check("rl_bo", 16'(Bo), 16'h0000);
        tick();
        check("rl_cnt", 16'(cnt), 16'h0000);
        check("rl_done", 16'(Done), 16'h0000);
        Res = 1'b0; Load = 1'b0; Mode = 2'b01;
        #1;
        check("rl_rld_bo", 16'(Bo), 16'h0001);
        tick();
        check("rl_rld_cnt", 16'(cnt), 16'h0000);
        En = 1'b0;

        // Reserved mode behaves as wrap.
        Mode = 2'b11; En = 1'b1;
        tick();
        check("rsvd_wrap", 16'(cnt), 16'h00FF);
        En = 1'b0;

        // Cascade: 16'h0100, then 1 and 256 enabled cycles.
        c_load = 1'b1;
        tick();
        c_load = 1'b0;
        check("cas_load", {hi_cnt, lo_cnt}, 16'h0100);
        c_en = 1'b1;
        tick();
        check("cas_1", {hi_cnt, lo_cnt}, 16'h00FF);
        for (int k = 0; k < 256; k++) tick();
        check("cas_257", {hi_cnt, lo_cnt}, 16'hFFFF);
        c_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
